// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
// Shared definitions for the MEM pipeline stage: access-size encodings,
// the FSM state type and helpers for byte-enable and alignment decisions.
// Helpers work on an 8-lane (64-bit) view of the data bus. Narrower
// datapaths truncate the mask and zero-extend the lane offset.
package mem_stage_pkg;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } mem_state_e;

   // Contiguous run of 2^size ones, shifted up to the addressed lane.
   function automatic logic [7:0] be_mask(input logic [1:0] size, input logic [2:0] off);
      logic [7:0] base;
      case (size)
         SZ_B:    base = 8'h01;
         SZ_H:    base = 8'h03;
         SZ_W:    base = 8'h0F;
         default: base = 8'hFF;
      endcase
      return base << off;
   endfunction

   // A doubleword is only legal on a 64-bit bus (has_dword=1).
   function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] off,
                                       input logic has_dword);
      logic ok;
      case (size)
         SZ_B:    ok = 1'b1;
         SZ_H:    ok = (off[0] == 1'b0);
         SZ_W:    ok = (off[1:0] == 2'b00);
         default: ok = has_dword && (off == 3'b000);
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// load_align
// Selects the addressed lane from a full-width read word and sign- or
// zero-extends it to DATA_W.
//   rdata : raw data-memory read word
//   off   : byte offset of the access within the word
//   size  : access size (SZ_B/SZ_H/SZ_W/SZ_D)
//   uns   : 1 = zero-extend, 0 = sign-extend
//   data  : extended, right-justified load result
module load_align
   import mem_stage_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0]            rdata,
   input  logic [$clog2(DATA_W/8)-1:0]  off,
   input  logic [1:0]                   size,
   input  logic                         uns,
   output logic [DATA_W-1:0]            data
);

   logic [DATA_W-1:0] lane;
   logic [DATA_W-1:0] keep;
   logic              fill;

   // Shift the addressed lane down to bit 0. The bits above the access
   // width are then either kept as zero or filled with the lane's sign bit.
   // A full-width access keeps every bit, so no extension applies.
   always_comb begin
      lane = rdata >> {off, 3'b000};
      keep = '1;
      fill = 1'b0;
      case (size)
         SZ_B: begin
            keep = DATA_W'(8'hFF);
            fill = lane[7];
         end
         SZ_H: begin
            keep = DATA_W'(16'hFFFF);
            fill = lane[15];
         end
         SZ_W: begin
            keep = DATA_W'(32'hFFFF_FFFF);
            fill = lane[31];
         end
         default: begin
            keep = '1;
            fill = 1'b0;
         end
      endcase
      data = (lane & keep) | ({DATA_W{~uns & fill}} & ~keep);
   end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage
// MEM pipeline stage with its MEM/WB register. It drives a variable-latency
// data-memory port through a req/ack handshake and stalls upstream while an
// access is outstanding. Misaligned accesses are suppressed and flagged.
//   clk, reset (async, active-low)
//   EX/MEM side : in_valid, reg_wr_en, mem_rd_en, mem_wr_en, mem_to_reg_wr,
//                 mem_size, mem_unsigned, reg_wr_addr, alu_result, mem_wr_data
//   stall_out   : hold EX/MEM and earlier stages
//   memory side : dmem_req/we/addr/be/wdata out, dmem_ack/rdata in
//   MEM/WB side : mem_wb_valid, mem_wb_reg_wr_en, mem_wb_mem_to_reg_wr,
//                 mem_wb_misalign, mem_wb_reg_wr_addr, mem_wb_mem_rd_data,
//                 mem_wb_alu_result
module mem_access_stage
   import mem_stage_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   input  logic                  reg_wr_en,
   input  logic                  mem_rd_en,
   input  logic                  mem_wr_en,
   input  logic                  mem_to_reg_wr,
   input  logic [1:0]            mem_size,
   input  logic                  mem_unsigned,
   input  logic [REG_ADDR_W-1:0] reg_wr_addr,
   input  logic [DATA_W-1:0]     alu_result,
   input  logic [DATA_W-1:0]     mem_wr_data,
   output logic                  stall_out,
   output logic                  dmem_req,
   output logic                  dmem_we,
   output logic [ADDR_W-1:0]     dmem_addr,
   output logic [DATA_W/8-1:0]   dmem_be,
   output logic [DATA_W-1:0]     dmem_wdata,
   input  logic                  dmem_ack,
   input  logic [DATA_W-1:0]     dmem_rdata,
   output logic                  mem_wb_valid,
   output logic                  mem_wb_reg_wr_en,
   output logic                  mem_wb_mem_to_reg_wr,
   output logic                  mem_wb_misalign,
   output logic [REG_ADDR_W-1:0] mem_wb_reg_wr_addr,
   output logic [DATA_W-1:0]     mem_wb_mem_rd_data,
   output logic [DATA_W-1:0]     mem_wb_alu_result
);

   localparam int NB = DATA_W / 8;
   localparam int L  = $clog2(NB);
   localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(NB - 1);

   mem_state_e state, next_state;

   logic              is_access, live_aligned, live_we;
   logic [L-1:0]      off_live;
   logic [ADDR_W-1:0] live_addr;
   logic [NB-1:0]     live_be;
   logic [DATA_W-1:0] live_wdata;

   logic                  lat_we, lat_uns, lat_reg_wr_en, lat_mem_to_reg_wr;
   logic [1:0]            lat_size;
   logic [L-1:0]          lat_off;
   logic [ADDR_W-1:0]     lat_addr;
   logic [NB-1:0]         lat_be;
   logic [DATA_W-1:0]     lat_wdata, lat_alu_result;
   logic [REG_ADDR_W-1:0] lat_reg_wr_addr;

   logic                  complete, latch_en;
   logic                  c_reg_wr_en, c_mem_to_reg_wr, c_misalign, c_uns;
   logic [1:0]            c_size;
   logic [L-1:0]          c_off;
   logic [REG_ADDR_W-1:0] c_reg_wr_addr;
   logic [DATA_W-1:0]     c_alu_result, load_data;

   // Decode the live EX/MEM slot into a request. When both enables are set,
   // the access counts as a read, so the write strobe requires rd_en low.
   // Store data is the low 2^size bytes repeated across all lanes.
   always_comb begin
      is_access    = in_valid & (mem_rd_en | mem_wr_en);
      live_we      = mem_wr_en & ~mem_rd_en;
      off_live     = alu_result[L-1:0];
      live_aligned = is_aligned(mem_size, 3'(off_live), DATA_W == 64);
      live_addr    = ADDR_W'(alu_result) & ~LOW_MASK;
      live_be      = NB'(be_mask(mem_size, 3'(off_live)));
      case (mem_size)
         SZ_B:    live_wdata = {NB{mem_wr_data[7:0]}};
         SZ_H:    live_wdata = {(NB/2){mem_wr_data[15:0]}};
         SZ_W:    live_wdata = {(NB/4){mem_wr_data[31:0]}};
         default: live_wdata = mem_wr_data;
      endcase
   end

   // In IDLE the port is driven straight from the live inputs, so an
   // immediate ack completes with no stall. WAIT replays the latched request
   // until the ack arrives. The upstream slot may advance in the ack cycle
   // because stall drops together with it.
   always_comb begin
      next_state      = state;
      dmem_req        = 1'b0;
      stall_out       = 1'b0;
      complete        = 1'b0;
      latch_en        = 1'b0;
      dmem_we         = live_we;
      dmem_addr       = live_addr;
      dmem_be         = live_be;
      dmem_wdata      = live_wdata;
      c_reg_wr_en     = reg_wr_en;
      c_mem_to_reg_wr = mem_to_reg_wr;
      c_reg_wr_addr   = reg_wr_addr;
      c_alu_result    = alu_result;
      c_size          = mem_size;
      c_uns           = mem_unsigned;
      c_off           = off_live;
      c_misalign      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (is_access && live_aligned) begin
               dmem_req = 1'b1;
               if (dmem_ack) begin
                  complete = 1'b1;
               end else begin
                  latch_en   = 1'b1;
                  stall_out  = 1'b1;
                  next_state = ST_WAIT;
               end
            end else if (in_valid) begin
               complete   = 1'b1;
               c_misalign = is_access;
            end
         end
         ST_WAIT: begin
            dmem_req        = 1'b1;
            dmem_we         = lat_we;
            dmem_addr       = lat_addr;
            dmem_be         = lat_be;
            dmem_wdata      = lat_wdata;
            stall_out       = ~dmem_ack;
            c_reg_wr_en     = lat_reg_wr_en;
            c_mem_to_reg_wr = lat_mem_to_reg_wr;
            c_reg_wr_addr   = lat_reg_wr_addr;
            c_alu_result    = lat_alu_result;
            c_size          = lat_size;
            c_uns           = lat_uns;
            c_off           = lat_off;
            if (dmem_ack) begin
               complete   = 1'b1;
               next_state = ST_IDLE;
            end
         end
         default: next_state = ST_IDLE;
      endcase
      // Nothing may be requested while reset is held.
      if (!reset) begin
         dmem_req = 1'b0;
      end
   end

   load_align #(.DATA_W(DATA_W)) u_load_align (
      .rdata (dmem_rdata),
      .off   (c_off),
      .size  (c_size),
      .uns   (c_uns),
      .data  (load_data)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= next_state;
   end

   // Capture the outstanding request so the port stays stable while
   // upstream is stalled.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lat_we            <= 1'b0;
         lat_uns           <= 1'b0;
         lat_size          <= '0;
         lat_off           <= '0;
         lat_addr          <= '0;
         lat_be            <= '0;
         lat_wdata         <= '0;
         lat_reg_wr_en     <= 1'b0;
         lat_mem_to_reg_wr <= 1'b0;
         lat_reg_wr_addr   <= '0;
         lat_alu_result    <= '0;
      end else if (latch_en) begin
         lat_we            <= live_we;
         lat_uns           <= mem_unsigned;
         lat_size          <= mem_size;
         lat_off           <= off_live;
         lat_addr          <= live_addr;
         lat_be            <= live_be;
         lat_wdata         <= live_wdata;
         lat_reg_wr_en     <= reg_wr_en;
         lat_mem_to_reg_wr <= mem_to_reg_wr;
         lat_reg_wr_addr   <= reg_wr_addr;
         lat_alu_result    <= alu_result;
      end
   end

   // MEM/WB register. A bubble clears only valid, write enable and the
   // misalign flag. The data fields hold their previous values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_wb_valid         <= 1'b0;
         mem_wb_reg_wr_en     <= 1'b0;
         mem_wb_mem_to_reg_wr <= 1'b0;
         mem_wb_misalign      <= 1'b0;
         mem_wb_reg_wr_addr   <= '0;
         mem_wb_mem_rd_data   <= '0;
         mem_wb_alu_result    <= '0;
      end else if (complete) begin
         mem_wb_valid         <= 1'b1;
         mem_wb_reg_wr_en     <= c_reg_wr_en & ~c_misalign;
         mem_wb_mem_to_reg_wr <= c_mem_to_reg_wr;
         mem_wb_misalign      <= c_misalign;
         mem_wb_reg_wr_addr   <= c_reg_wr_addr;
         mem_wb_mem_rd_data   <= load_data;
         mem_wb_alu_result    <= c_alu_result;
      end else begin
         mem_wb_valid         <= 1'b0;
         mem_wb_reg_wr_en     <= 1'b0;
         mem_wb_misalign      <= 1'b0;
      end
   end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Parametrised MEM pipeline stage with MEM/WB register, sitting between the EX/MEM register and write-back. It drives a variable-latency data-memory port through a req/ack handshake and stalls the upstream pipeline while an access is outstanding. It supports byte, half, word and (at 64-bit width) doubleword accesses, using little-endian byte enables and sign/zero extension of loads. Misaligned accesses are suppressed and flagged.

## Interface
- DATA_W, 32: datapath width; legal values are 32 or 64.
- ADDR_W, 32: byte-address width.
- REG_ADDR_W, 5: register-file address width.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  EX/MEM slot holds a valid instruction.
- reg_wr_en, mem_rd_en, mem_wr_en, mem_to_reg_wr  in  1 each  control bits from EX/MEM.
- mem_size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = doubleword (legal only when DATA_W=64).
- mem_unsigned  in  1  zero-extend the load when set; sign-extend when clear.
- reg_wr_addr  in  REG_ADDR_W  destination register.
- alu_result  in  DATA_W  effective byte address, or the ALU result for non-memory instructions.
- mem_wr_data  in  DATA_W  store data, right-justified.
- stall_out  out  1  hold EX/MEM and earlier stages.
- dmem_req, dmem_we  out  1  memory request and write strobe.
- dmem_addr  out  ADDR_W  word-aligned address (low log2(DATA_W/8) bits are 0).
- dmem_be  out  DATA_W/8  byte enables.
- dmem_wdata  out  DATA_W  lane-replicated store data.
- dmem_ack  in  1  request completed this cycle.
- dmem_rdata  in  DATA_W  read data; valid when dmem_ack=1.
- mem_wb_valid, mem_wb_reg_wr_en, mem_wb_mem_to_reg_wr, mem_wb_misalign  out  1 each.
- mem_wb_reg_wr_addr  out  REG_ADDR_W.
- mem_wb_mem_rd_data, mem_wb_alu_result  out  DATA_W.

## Operation
- Access definition: an access is `in_valid & (mem_rd_en | mem_wr_en)`. If both enables are set, the access is treated as a read.
- Lane offset: `off = alu_result[L-1:0]`, where L = log2(DATA_W/8).
- Alignment rule: the access is aligned when `off` is a multiple of 2^mem_size. mem_size=3 with DATA_W=32 counts as misaligned.
- Store byte enables: `dmem_be = ((1<<2^mem_size)-1) << off`.
- Store data: the low 2^mem_size bytes of mem_wr_data are replicated across every lane of dmem_wdata.
- Load path: the lane at `off` is selected from dmem_rdata, then extended to DATA_W per mem_unsigned.
- FSM states: IDLE and WAIT.
- IDLE, aligned access:
  - dmem_req=1 combinationally, using the live inputs.
  - dmem_ack=1 in the same cycle: the instruction completes now, stall_out=0, and the FSM stays in IDLE.
  - No ack: latch addr, be, wdata, we, size, unsigned, off and the control bits; go to WAIT; stall_out=1.
- WAIT:
  - dmem_req=1, driven from the latched values.
  - stall_out = !dmem_ack.
  - On ack: complete using the latched fields and return to IDLE.
- Misaligned access: dmem_req=0 and no stall. The instruction completes with mem_wb_reg_wr_en=0 and mem_wb_misalign=1.
- Non-memory instruction: completes in one cycle; dmem_req=0.
- Completion: loads the MEM/WB register with valid=1, the control bits, the extended load data and alu_result.
- Non-completion cycles (stalled, or in_valid=0): MEM/WB loads a bubble. Bubble values: valid=0, reg_wr_en=0, misalign=0; the data fields are don't-care but are required to hold their previous values.

## Timing
- Reset (reset=0, asynchronous): FSM goes to IDLE; all latches and all mem_wb_* outputs clear to 0. With the FSM in IDLE, dmem_req=0.
- Reset asserted during WAIT: the request drops immediately and the outstanding ack is ignored after release. The memory side is required to tolerate the abandoned request.
- Latency:
  - Non-memory, misaligned, or ack-in-same-cycle: MEM/WB is updated at the next clock edge.
  - N-cycle memory latency: stall_out is high for N cycles, and the result appears at the clock edge after the ack.
- dmem_req stays asserted, with stable addr/be/wdata/we, from issue until the cycle of ack inclusive.
- Back-to-back accesses: in the cycle after an ack, a new IDLE request may issue. The FSM inserts no dead cycle.
- stall_out is purely combinational from the FSM state, dmem_ack and the IDLE inputs. It has no dependency on mem_wb_*.

## Structure
- Package mem_stage_pkg holds:
  - mem_size encodings (SZ_B, SZ_H, SZ_W, SZ_D);
  - FSM state enum;
  - helper functions for the byte-enable mask and the alignment check.
- Sub-module load_align: combinational lane select plus sign/zero extension, parametrised by DATA_W. It is instantiated once, on the completion path.
- The MEM/WB register and FSM live in the top module.

## Test plan
- Word load, zero latency, DATA_W=32: addr 0x1004, rdata 0xDEADBEEF, ack in same cycle. Required: dmem_addr 0x1004, be 0xF, stall never asserted; next cycle mem_wb_mem_rd_data=0xDEADBEEF, valid=1.
- Byte load, sign and zero extension: addr 0x2003, rdata 0x80112233. Required: signed result 0xFFFFFF80; unsigned result 0x00000080.
- Half store, 3-cycle latency: addr 0x3002, data 0x0000ABCD. Required: be 0xC, wdata 0xABCDABCD; stall_out high for 3 cycles; MEM/WB bubbles (valid=0) during those cycles; then one valid completion.
- Misaligned word store at 0x4001. Required: dmem_req stays 0 and no write occurs; next cycle mem_wb_misalign=1 and mem_wb_reg_wr_en=0.
- Two back-to-back loads, each acked after 1 cycle. Required: second req asserted in the cycle after the first ack; two valid completions, 2 cycles apart.
- Reset asserted mid-WAIT. Required: dmem_req and all mem_wb_* go to 0 without waiting for a clock edge; after release, a late ack produces no completion.
- DATA_W=64 doubleword at 0x8. Required: be 0xFF. mem_size=3 at 0xC must be flagged misaligned.
